vga_rect_fb: RTL and testbench
==============================

Name: vga_rect_fb

Overview:
- Low-resolution 12-bit frame buffer sitting directly upstream of the VGA controller.
- The controller sends registered row/col addresses and the active-low read strobe. This block returns the pixel word in the bbbb_gggg_rrrr format the controller samples on its next edge.
- Frame-buffer contents are written by an internal rectangle-fill engine. A host drives the engine through a valid/ready command port.
- Each stored pixel is displayed as a 2^SCALE_SHIFT x 2^SCALE_SHIFT block on the 640x480 screen.

Parameters:
FB_W, 160, frame-buffer width in stored pixels (640 >> SCALE_SHIFT)
FB_H, 120, frame-buffer height in stored pixels (480 >> SCALE_SHIFT)
SCALE_SHIFT, 2, log2 of screen pixels per stored pixel in each axis

Ports:
vga_clk  in  1  25 MHz pixel clock; all state updates on rising edge
clrn  in  1  reset, synchronous, active-low
row_addr  in  9  screen row from VGA controller (0-479 valid)
col_addr  in  10  screen column from VGA controller (0-639 valid)
rdn  in  1  read strobe from VGA controller, active-low
d_out  out  12  pixel word bbbb_gggg_rrrr, drives controller d_in
cmd_valid  in  1  host fill command valid
cmd_ready  out  1  engine accepts a command this cycle
cmd_x0  in  8  rectangle left column (stored-pixel units)
cmd_y0  in  7  rectangle top row
cmd_x1  in  8  rectangle right column, inclusive
cmd_y1  in  7  rectangle bottom row, inclusive
cmd_color  in  12  fill colour, bbbb_gggg_rrrr
busy  out  1  fill in progress (any state but IDLE)
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Clock and reset: one clock, vga_clk. Reset clrn is synchronous and active-low.
- Storage: FB_W*FB_H words x 12 bits. Read is asynchronous (distributed RAM); write is synchronous. Contents are not cleared by reset.
- Read path (combinational, zero latency from the address inputs):
  - fx = col_addr >> SCALE_SHIFT, fy = row_addr >> SCALE_SHIFT, index = fy*FB_W + fx.
  - d_out = mem[index] when rdn=0 and fx<FB_W and fy<FB_H; otherwise d_out = 12'h000.
  - The read path never stalls and has priority over nothing. A write to the same index in the same cycle returns the old value; the new value is visible from the next cycle.
- FSM states: IDLE, CHECK, FILL, DONE.
- Reset (clrn=0 at an edge): state=IDLE, cmd_ready=1, busy=0, done=0, counters=0. A reset during FILL aborts the fill; pixels already written stay written.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid=1, latch x0, y0, x1, y1 and colour, then go to CHECK.
  - cmd_ready is 0 in every other state, so commands presented while busy are held off, not dropped.
- CHECK (one cycle):
  - Clip: x1c = min(x1, FB_W-1), y1c = min(y1, FB_H-1).
  - Empty when x0>=FB_W, y0>=FB_H, x0>x1c, or y0>y1c. Empty goes to DONE with no writes; otherwise load cx=x0, cy=y0 and go to FILL.
- FILL:
  - One write per cycle: mem[cy*FB_W+cx] <= colour.
  - Raster order: cx increments; at cx==x1c, cx reloads x0 and cy increments. The write at (x1c, y1c) goes to DONE.
  - Index arithmetic is 15 bits wide, with no wrap beyond FB_W*FB_H-1 (guaranteed by clipping).
- DONE (one cycle): done=1, then IDLE.
- Latency: handshake in cycle 0, CHECK in cycle 1, N writes in cycles 2..N+1, done=1 in cycle N+2, cmd_ready=1 in cycle N+3. An empty command gives done in cycle 2.
- busy = (state != IDLE). The handshake cycle itself shows busy=0.

Test Plan:
1. Reset: clrn=0 for 2 cycles, then release → cmd_ready=1, busy=0, done=0, no memory writes.
2. Full clear: command (0,0,159,119,12'h000) → exactly 19200 writes, done in cycle 19202. Afterwards, any rdn=0 read in 0-639/0-479 returns 12'h000.
3. Small rectangle: after the clear, command (10,5,12,6,12'hF0A) → 6 writes, done in cycle 8. row=20,col=40 gives 12'hF0A; row=27,col=51 gives 12'hF0A; row=28,col=40 gives 12'h000; row=20,col=52 gives 12'h000.
4. Clipping and empty: (150,110,255,127,12'h0F0) → exactly 10*10=100 writes. (20,5,10,5,x) → zero writes, done in cycle 2. (200,0,210,0,x) → zero writes.
5. Read gating: rdn=1 with any address → d_out=12'h000. rdn=0 with col_addr=700 → d_out=12'h000.
6. Back-pressure and mid-fill reset: hold cmd_valid=1 during a fill → cmd_ready=0 and the second command is accepted only in the cycle after done. Assert clrn=0 mid-fill → next cycle is IDLE with cmd_ready=1; previously written pixels keep the fill colour and unwritten ones are unchanged.

Source files
------------

// File: rtl/vga_rect_fb.sv
// vga_rect_fb: 12-bit low-resolution frame buffer feeding a 640x480 VGA
// controller. It has a combinational read port driven by the controller's
// row/col addresses and a rectangle-fill engine that writes the buffer.
// The engine receives commands from a host over a valid/ready port.
//
// Ports:
//   vga_clk      pixel clock, all state updates on the rising edge
//   clrn         synchronous active-low reset
//   row_addr     screen row (0-479), col_addr screen column (0-639)
//   rdn          active-low read strobe; d_out is zero when it is high
//   d_out        pixel word bbbb_gggg_rrrr (combinational)
//   cmd_valid    host command valid; cmd_ready is high only while idle
//   cmd_x0/x1    rectangle columns, inclusive, in stored-pixel units
//   cmd_y0/y1    rectangle rows, inclusive, in stored-pixel units
//   cmd_color    fill colour bbbb_gggg_rrrr
//   busy         engine is not idle
//   done         one-cycle pulse when a command completes
module vga_rect_fb #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        vga_clk,
    input  logic        clrn,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    output logic [11:0] d_out,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x0,
    input  logic [6:0]  cmd_y0,
    input  logic [7:0]  cmd_x1,
    input  logic [6:0]  cmd_y1,
    input  logic [11:0] cmd_color,
    output logic        busy,
    output logic        done
);

    localparam int DEPTH = FB_W * FB_H;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_x0;
    logic [6:0]  r_y0;
    logic [7:0]  r_x1;
    logic [6:0]  r_y1;
    logic [11:0] r_color;
    logic [7:0]  r_x1c;
    logic [6:0]  r_y1c;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic        r_cmd_ready;
    logic        r_busy;
    logic        r_done;

    logic [11:0] r_mem [0:DEPTH-1];

    logic [7:0]       w_x1c;
    logic [6:0]       w_y1c;
    logic             w_empty;
    logic             w_row_end;
    logic             w_last;
    logic             w_we;
    logic [IDX_W-1:0] w_wr_idx;
    logic [9:0]       w_fx;
    logic [8:0]       w_fy;
    logic             w_rd_ok;
    logic [IDX_W-1:0] w_rd_idx;

    // Clip the latched corner to the buffer and classify the rectangle.
    always_comb begin
        w_x1c   = (r_x1 > 8'(FB_W - 1)) ? 8'(FB_W - 1) : r_x1;
        w_y1c   = (r_y1 > 7'(FB_H - 1)) ? 7'(FB_H - 1) : r_y1;
        w_empty = (r_x0 >= 8'(FB_W)) || (r_y0 >= 7'(FB_H)) ||
                  (r_x0 > w_x1c) || (r_y0 > w_y1c);
        w_row_end = (r_cx == r_x1c);
        w_last    = w_row_end && (r_cy == r_y1c);
        // A reset edge that lands during FILL must not commit one more pixel.
        w_we      = (r_state == ST_FILL) && clrn;
        w_wr_idx  = IDX_W'(r_cy) * IDX_W'(FB_W) + IDX_W'(r_cx);
    end

    // Next-state logic of the fill engine.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_next = ST_CHECK;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (w_empty) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_FILL;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register and registered status outputs decoded from next state.
    always_ff @(posedge vga_clk) begin
        if (!clrn) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == ST_IDLE);
            r_busy      <= (w_next != ST_IDLE);
            r_done      <= (w_next == ST_DONE);
        end
    end

    // Command latch, clip registers and raster counters.
    always_ff @(posedge vga_clk) begin
        if (!clrn) begin
            r_x0    <= 8'd0;
            r_y0    <= 7'd0;
            r_x1    <= 8'd0;
            r_y1    <= 7'd0;
            r_color <= 12'h000;
            r_x1c   <= 8'd0;
            r_y1c   <= 7'd0;
            r_cx    <= 8'd0;
            r_cy    <= 7'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_x0    <= cmd_x0;
                        r_y0    <= cmd_y0;
                        r_x1    <= cmd_x1;
                        r_y1    <= cmd_y1;
                        r_color <= cmd_color;
                    end
                end
                ST_CHECK: begin
                    r_x1c <= w_x1c;
                    r_y1c <= w_y1c;
                    r_cx  <= r_x0;
                    r_cy  <= r_y0;
                end
                ST_FILL: begin
                    if (w_row_end) begin
                        r_cx <= r_x0;
                        r_cy <= r_cy + 7'd1;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                end
                default: begin
                    r_cx <= r_cx;
                end
            endcase
        end
    end

    // Frame-buffer write port; contents deliberately survive reset.
    always_ff @(posedge vga_clk) begin
        if (w_we) begin
            r_mem[w_wr_idx] <= r_color;
        end
    end

    // Asynchronous read: scale screen coordinates down to stored pixels.
    always_comb begin
        w_fx     = col_addr >> SCALE_SHIFT;
        w_fy     = row_addr >> SCALE_SHIFT;
        w_rd_ok  = !rdn && (w_fx < 10'(FB_W)) && (w_fy < 9'(FB_H));
        w_rd_idx = IDX_W'(w_fy) * IDX_W'(FB_W) + IDX_W'(w_fx);
        d_out    = 12'h000;
        if (w_rd_ok) begin
            d_out = r_mem[w_rd_idx];
        end else begin
            d_out = 12'h000;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_vga_rect_fb.sv
// Self-checking bench for vga_rect_fb. A reference image of the buffer is
// kept in the bench; expected done cycles and pixel words are queued when
// stimulus is driven and popped when the DUT output is sampled.
module tb_vga_rect_fb;

    logic        vga_clk = 1'b0;
    logic        clrn;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [11:0] d_out;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_x0;
    logic [6:0]  cmd_y0;
    logic [7:0]  cmd_x1;
    logic [6:0]  cmd_y1;
    logic [11:0] cmd_color;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          done_q[$];
    logic [11:0] pix_q[$];
    logic [11:0] model [0:19199];

    vga_rect_fb dut (
        .vga_clk   (vga_clk),
        .clrn      (clrn),
        .row_addr  (row_addr),
        .col_addr  (col_addr),
        .rdn       (rdn),
        .d_out     (d_out),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_x1    (cmd_x1),
        .cmd_y1    (cmd_y1),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done)
    );

    always #20 vga_clk = ~vga_clk;

    // Reference fill with clipping; returns the number of pixels written.
    task automatic model_fill(input int x0, y0, x1, y1, input logic [11:0] c,
                              output int n);
        int x1c, y1c;
        x1c = (x1 > 159) ? 159 : x1;
        y1c = (y1 > 119) ? 119 : y1;
        n = 0;
        if (!(x0 >= 160 || y0 >= 120 || x0 > x1c || y0 > y1c)) begin
            for (int y = y0; y <= y1c; y++)
                for (int x = x0; x <= x1c; x++) begin
                    model[y*160 + x] = c;
                    n++;
                end
        end
    endtask

    function automatic logic [11:0] model_px(input int row, col, input logic rd);
        if (rd == 1'b0 && (col / 4) < 160 && (row / 4) < 120)
            return model[(row/4)*160 + col/4];
        return 12'h000;
    endfunction

    // Present a read address and queue the expected pixel word.
    task automatic read_px(input int row, col, input logic rd, input logic [11:0] e);
        row_addr = row[8:0];
        col_addr = col[9:0];
        rdn      = rd;
        pix_q.push_back(e);
        #1;
    endtask

    // Handshake a command (starting just after a negedge); returns in cycle 1.
    task automatic issue_cmd(input int x0, y0, x1, y1, input logic [11:0] c);
        int n;
        model_fill(x0, y0, x1, y1, c, n);
        done_q.push_back(n + 2);
        cmd_x0 = x0[7:0]; cmd_y0 = y0[6:0];
        cmd_x1 = x1[7:0]; cmd_y1 = y1[6:0];
        cmd_color = c;
        cmd_valid = 1'b1;
        @(posedge vga_clk);
        @(negedge vga_clk);
        cmd_valid = 1'b0;
    endtask

    // Count cycles from cycle 1 until done is seen, bounded.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 25000) begin
            @(negedge vga_clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        clrn = 1'b0; cmd_valid = 1'b0; rdn = 1'b1;
        row_addr = 9'd0; col_addr = 10'd0;
        cmd_x0 = 8'd0; cmd_y0 = 7'd0; cmd_x1 = 8'd0; cmd_y1 = 7'd0;
        cmd_color = 12'h000;
        repeat (2) @(posedge vga_clk);
        @(negedge vga_clk);
        clrn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if ({cmd_ready, busy, done} !== 3'b100) begin
                n_fail++;
                $display("FAIL reset_flags[%0d]: ready/busy/done=%b expected 100", k, {cmd_ready, busy, done});
            end
            @(negedge vga_clk);
        end
    endtask

    task automatic test_full_clear();
        int cyc, e, r, c;
        logic [11:0] act, ex;
        issue_cmd(0, 0, 159, 119, 12'h000);
        n_tests++;
        if ({cmd_ready, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL clear_check_state: ready/busy=%b expected 01", {cmd_ready, busy});
        end
        wait_done(cyc);
        e = done_q.pop_front();
        n_tests++;
        if (cyc !== e) begin
            n_fail++;
            $display("FAIL clear_done_cycle: got %0d expected %0d", cyc, e);
        end
        @(negedge vga_clk);
        n_tests++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL clear_back_idle: ready/busy/done=%b expected 100", {cmd_ready, busy, done});
        end
        for (int k = 0; k < 40; k++) begin
            r = (k == 0) ? 0 : (k == 1) ? 479 : $urandom_range(479);
            c = (k == 0) ? 0 : (k == 1) ? 639 : $urandom_range(639);
            read_px(r, c, 1'b0, 12'h000);
            act = d_out; ex = pix_q.pop_front();
            n_tests++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL clear_read r=%0d c=%0d: got %h expected %h", r, c, act, ex);
            end
        end
    endtask

    task automatic test_small_rect();
        int cyc, e;
        logic [11:0] act, ex;
        int rows [4] = '{20, 27, 28, 20};
        int cols [4] = '{40, 51, 40, 52};
        logic [11:0] exps [4] = '{12'hF0A, 12'hF0A, 12'h000, 12'h000};
        issue_cmd(10, 5, 12, 6, 12'hF0A);
        wait_done(cyc);
        e = done_q.pop_front();
        n_tests++;
        if (cyc !== e || e != 8) begin
            n_fail++;
            $display("FAIL small_done_cycle: got %0d expected 8", cyc);
        end
        @(negedge vga_clk);
        for (int k = 0; k < 4; k++) begin
            read_px(rows[k], cols[k], 1'b0, exps[k]);
            act = d_out; ex = pix_q.pop_front();
            n_tests++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL small_read r=%0d c=%0d: got %h expected %h", rows[k], cols[k], act, ex);
            end
        end
    endtask

    task automatic test_clip_empty();
        int cyc, e;
        logic [11:0] act, ex;
        int rows [5] = '{479, 440, 440, 436, 20};
        int cols [5] = '{639, 600, 596, 600, 80};
        issue_cmd(150, 110, 255, 127, 12'h0F0);
        wait_done(cyc);
        e = done_q.pop_front();
        n_tests++;
        if (cyc !== e || e != 102) begin
            n_fail++;
            $display("FAIL clip_done_cycle: got %0d expected 102", cyc);
        end
        @(negedge vga_clk);
        issue_cmd(20, 5, 10, 5, 12'h555);
        wait_done(cyc);
        e = done_q.pop_front();
        n_tests++;
        if (cyc !== e || e != 2) begin
            n_fail++;
            $display("FAIL empty_x_done_cycle: got %0d expected 2", cyc);
        end
        @(negedge vga_clk);
        issue_cmd(200, 0, 210, 0, 12'h777);
        wait_done(cyc);
        e = done_q.pop_front();
        n_tests++;
        if (cyc !== e || e != 2) begin
            n_fail++;
            $display("FAIL empty_off_done_cycle: got %0d expected 2", cyc);
        end
        @(negedge vga_clk);
        for (int k = 0; k < 5; k++) begin
            read_px(rows[k], cols[k], 1'b0, model_px(rows[k], cols[k], 1'b0));
            act = d_out; ex = pix_q.pop_front();
            n_tests++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL clip_read r=%0d c=%0d: got %h expected %h", rows[k], cols[k], act, ex);
            end
        end
    endtask

    task automatic test_read_gating();
        logic [11:0] act, ex;
        int rows [4] = '{479, 20, 20, 490};
        int cols [4] = '{639, 40, 700, 40};
        logic rds [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            read_px(rows[k], cols[k], rds[k], 12'h000);
            act = d_out; ex = pix_q.pop_front();
            n_tests++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL gate_read r=%0d c=%0d rdn=%b: got %h expected %h", rows[k], cols[k], rds[k], act, ex);
            end
        end
    endtask

    task automatic test_back_to_back();
        int na, nb, cyc;
        logic [11:0] act, ex;
        int rows [3] = '{120, 120, 164};
        int cols [3] = '{132, 136, 164};
        model_fill(30, 30, 33, 30, 12'h123, na);
        cmd_x0 = 8'd30; cmd_y0 = 7'd30; cmd_x1 = 8'd33; cmd_y1 = 7'd30;
        cmd_color = 12'h123; cmd_valid = 1'b1;
        @(posedge vga_clk);
        @(negedge vga_clk);
        cmd_x0 = 8'd40; cmd_y0 = 7'd40; cmd_x1 = 8'd41; cmd_y1 = 7'd41;
        cmd_color = 12'h456;
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin
            n_tests++;
            if (cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_held_off cycle %0d: ready=%b expected 0", cyc, cmd_ready);
            end
            @(negedge vga_clk);
            cyc++;
        end
        n_tests++;
        if (cyc !== na + 2) begin
            n_fail++;
            $display("FAIL b2b_first_done: got %0d expected %0d", cyc, na + 2);
        end
        @(negedge vga_clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready_after_done: got %b expected 1", cmd_ready);
        end
        model_fill(40, 40, 41, 41, 12'h456, nb);
        done_q.push_back(nb + 2);
        @(posedge vga_clk);
        @(negedge vga_clk);
        cmd_valid = 1'b0;
        wait_done(cyc);
        nb = done_q.pop_front();
        n_tests++;
        if (cyc !== nb) begin
            n_fail++;
            $display("FAIL b2b_second_done: got %0d expected %0d", cyc, nb);
        end
        @(negedge vga_clk);
        for (int k = 0; k < 3; k++) begin
            read_px(rows[k], cols[k], 1'b0, model_px(rows[k], cols[k], 1'b0));
            act = d_out; ex = pix_q.pop_front();
            n_tests++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL b2b_read r=%0d c=%0d: got %h expected %h", rows[k], cols[k], act, ex);
            end
        end
    endtask

    task automatic test_midfill_reset();
        int cyc, e;
        logic [11:0] act, ex;
        int rows [6] = '{240, 248, 248, 252, 276, 244};
        int cols [6] = '{0, 316, 324, 0, 636, 639};
        cmd_x0 = 8'd0; cmd_y0 = 7'd60; cmd_x1 = 8'd159; cmd_y1 = 7'd69;
        cmd_color = 12'hABC; cmd_valid = 1'b1;
        @(posedge vga_clk);
        @(negedge vga_clk);
        cmd_valid = 1'b0;
        // Writes land on edges 2..401 (pixels 0..399); edge 402 sees reset.
        repeat (401) @(negedge vga_clk);
        clrn = 1'b0;
        @(negedge vga_clk);
        n_tests++;
        if ({cmd_ready, busy, done} !== 3'b100) begin
            n_fail++;
            $display("FAIL midfill_abort_idle: ready/busy/done=%b expected 100", {cmd_ready, busy, done});
        end
        clrn = 1'b1;
        for (int p = 0; p < 400; p++) model[(60 + p/160)*160 + p%160] = 12'hABC;
        for (int k = 0; k < 6; k++) begin
            read_px(rows[k], cols[k], 1'b0, model_px(rows[k], cols[k], 1'b0));
            act = d_out; ex = pix_q.pop_front();
            n_tests++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL midfill_read r=%0d c=%0d: got %h expected %h", rows[k], cols[k], act, ex);
            end
        end
        @(negedge vga_clk);
        issue_cmd(5, 100, 6, 100, 12'h9C3);
        wait_done(cyc);
        e = done_q.pop_front();
        n_tests++;
        if (cyc !== e) begin
            n_fail++;
            $display("FAIL post_reset_done: got %0d expected %0d", cyc, e);
        end
        @(negedge vga_clk);
        read_px(400, 24, 1'b0, model_px(400, 24, 1'b0));
        act = d_out; ex = pix_q.pop_front();
        n_tests++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL post_reset_read: got %h expected %h", act, ex);
        end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) model[i] = 12'h000;
        test_reset();
        test_full_clear();
        test_small_rect();
        test_clip_empty();
        test_read_gating();
        test_back_to_back();
        test_midfill_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
